// File: rtl/pwm_pkg.sv
// Shared types and constants for the pwm duty-cycle fade sequencer.
package pwm_pkg;

  localparam int unsigned DC_W   = 7;
  localparam int unsigned DC_MAX = 100;
  localparam int unsigned RATE_W = 8;

  typedef logic [DC_W-1:0]   dc_t;
  typedef logic [RATE_W-1:0] rate_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Load handshake carrying a new target duty and step rate into the fade controller.
interface pwm_fade_ctrl_if #(
  parameter int unsigned DC_W   = pwm_pkg::DC_W,
  parameter int unsigned RATE_W = pwm_pkg::RATE_W
);

  logic              load_valid;
  logic              load_ready;
  logic [DC_W-1:0]   tgt_dc;
  logic [RATE_W-1:0] rate;

  modport master (
    output load_valid,
    output tgt_dc,
    output rate,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  tgt_dc,
    input  rate,
    output load_ready
  );

endinterface

// File: rtl/fade_tick_gen.sv
// Step prescaler: counts enabled cycles and pulses tick when the count reaches rate.
module fade_tick_gen #(
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] cnt_d;
  logic              at_end;

  always_comb begin
    at_end = (cnt_q == rate);
    tick   = enable && at_end;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_end ? '0 : cnt_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer: ramps dc_out one percent per tick toward a loaded target.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DC_W   = 7,
  parameter int unsigned DC_MAX = 100,
  parameter int unsigned RATE_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_fade_ctrl_if.slave  ld,
  input  logic            hold,
  output logic [DC_W-1:0] dc_out,
  output logic            busy,
  output logic            done
);

  localparam logic [DC_W-1:0] DC_MAX_V = DC_W'(DC_MAX);

  state_e            state_q, state_d;
  logic [DC_W-1:0]   tgt_q, tgt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [DC_W-1:0]   dc_q, dc_d;
  logic              done_q, done_d;

  logic              accept;
  logic [DC_W-1:0]   tgt_clamped;
  logic [DC_W-1:0]   dc_step;
  logic              tick;
  logic              tick_clear;
  logic              tick_en;

  always_comb begin
    ld.load_ready = !hold;
    accept        = ld.load_valid && !hold;
    tgt_clamped   = (ld.tgt_dc > DC_MAX_V) ? DC_MAX_V : ld.tgt_dc;
    tick_clear    = accept || (state_q == IDLE);
    tick_en       = (state_q == RAMP) && !hold;
  end

  fade_tick_gen #(
    .RATE_W (RATE_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tick_clear),
    .enable (tick_en),
    .rate   (rate_q),
    .tick   (tick)
  );

  // Direction is re-derived every step; saturate at both rails.
  always_comb begin
    dc_step = dc_q;
    if (dc_q < tgt_q) begin
      dc_step = (dc_q >= DC_MAX_V) ? DC_MAX_V : dc_q + DC_W'(1);
    end else if (dc_q > tgt_q) begin
      dc_step = (dc_q == '0) ? '0 : dc_q - DC_W'(1);
    end
  end

  // A load on a step edge wins: the step and its done pulse are dropped.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    if (accept) begin
      tgt_d  = tgt_clamped;
      rate_d = ld.rate;
      if (tgt_clamped == dc_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if ((state_q == RAMP) && tick) begin
      dc_d = dc_step;
      if (dc_step == tgt_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      rate_q  <= '0;
      dc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dc_out = dc_q;
    busy   = (state_q == RAMP);
    done   = done_q;
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: loads are queued by stimulus, a monitor checks every cycle against an arithmetic ramp model.
module tb_pwm_fade_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold  = 1'b0;
  logic [6:0] dc_out;
  logic       busy;
  logic       done;

  pwm_fade_ctrl_if #(.DC_W(7), .RATE_W(8)) ld_if ();

  pwm_fade_ctrl #(.DC_W(7), .DC_MAX(100), .RATE_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (ld_if.slave),
    .hold   (hold),
    .dc_out (dc_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int rate;
  } load_t;

  load_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: dc = start + dir * min(N, active_cycles / (rate+1)), active = non-hold edges since accept.
  initial begin
    int    m_dc, m_start, m_tgt, m_rate, m_active, m_steps, m_n;
    int    m_ramping, m_done_exp, acc, hd, rs;
    load_t tr;
    m_dc = 0; m_start = 0; m_tgt = 0; m_rate = 0; m_active = 0;
    m_ramping = 0; m_done_exp = 0;
    forever begin
      @(posedge clk);
      rs  = int'(rst_n);
      hd  = int'(hold);
      acc = int'(ld_if.load_valid && !hold && rst_n);
      #1;
      m_done_exp = 0;
      if (rs == 0 || !rst_n) begin
        m_dc = 0;
        m_ramping = 0;
      end else if (acc != 0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: accept seen with no queued load at %0t", $time);
        end else begin
          tr       = exp_q.pop_front();
          m_tgt    = (tr.tgt > 100) ? 100 : tr.tgt;
          m_rate   = tr.rate;
          m_start  = m_dc;
          m_active = 0;
          if (m_tgt == m_dc) begin
            m_ramping  = 0;
            m_done_exp = 1;
          end else begin
            m_ramping = 1;
          end
        end
      end else if (m_ramping != 0 && hd == 0) begin
        m_active++;
        m_steps = m_active / (m_rate + 1);
        m_n     = (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
        if (m_steps >= m_n) begin
          m_dc       = m_tgt;
          m_ramping  = 0;
          m_done_exp = 1;
        end else begin
          m_dc = (m_tgt > m_start) ? m_start + m_steps : m_start - m_steps;
        end
      end
      check("dc_out", 32'(dc_out), 32'(m_dc));
      check("done", 32'(done), 32'(m_done_exp));
      check("busy", 32'(busy), 32'(m_ramping));
      check("load_ready", 32'(ld_if.load_ready), 32'(!hold));
      if (m_done_exp != 0) check("done_at_target", 32'(dc_out), 32'(m_tgt));
    end
  end

  task automatic issue_load(input int t, input int r);
    ld_if.tgt_dc     = 7'(t);
    ld_if.rate       = 8'(r);
    ld_if.load_valid = 1'b1;
    exp_q.push_back('{t, r});
    @(negedge clk);
    ld_if.load_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!done && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (!done) check("wait_done_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_dc(input int v, input int bound);
    int i = 0;
    while (int'(dc_out) != v && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (int'(dc_out) != v) check("wait_dc_timeout", 32'(dc_out), 32'(v));
  endtask

  task automatic settle_at(input int v);
    issue_load(v, 0);
    wait_done(300);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int t, r, i;
    int seen;
    ld_if.load_valid = 1'b0;
    ld_if.tgt_dc     = '0;
    ld_if.rate       = '0;
    repeat (3) @(negedge clk);
    check("rst_dc", 32'(dc_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(ld_if.load_ready), 32'd1);

    // 0 -> 10 at rate 3: 10 steps of 4 cycles
    issue_load(10, 3);
    c0 = cyc;
    wait_done(200);
    check("ramp10_cycles", 32'(cyc - c0), 32'd40);
    check("ramp10_dc", 32'(dc_out), 32'd10);
    @(negedge clk);
    check("ramp10_busy_after", 32'(busy), 32'd0);

    // Clamp: 95 -> 120 ends at 100
    settle_at(95);
    issue_load(120, 0);
    c0 = cyc;
    wait_done(50);
    check("clamp_cycles", 32'(cyc - c0), 32'd5);
    check("clamp_dc", 32'(dc_out), 32'd100);
    @(negedge clk);

    // Hold for 5 cycles at 20 during 0 -> 50
    settle_at(0);
    issue_load(50, 0);
    c0 = cyc;
    wait_dc(20, 100);
    hold = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_dc", 32'(dc_out), 32'd20);
    check("hold_ready", 32'(ld_if.load_ready), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    wait_done(100);
    check("hold_total_cycles", 32'(cyc - c0), 32'd55);
    @(negedge clk);

    // Retarget at 30 while ramping to 60
    settle_at(0);
    issue_load(60, 0);
    wait_dc(30, 100);
    issue_load(10, 1);
    c0 = cyc;
    wait_done(200);
    check("retarget_cycles", 32'(cyc - c0), 32'd40);
    check("retarget_dc", 32'(dc_out), 32'd10);
    @(negedge clk);

    // Target equal to current duty
    settle_at(25);
    issue_load(25, 3);
    check("equal_done", 32'(done), 32'd1);
    check("equal_busy", 32'(busy), 32'd0);
    check("equal_dc", 32'(dc_out), 32'd25);
    @(negedge clk);

    // Load collides with the final step edge of 0 -> 3
    settle_at(0);
    issue_load(3, 0);
    wait_dc(2, 20);
    issue_load(10, 0);
    c0 = cyc;
    wait_done(50);
    check("collide_cycles", 32'(cyc - c0), 32'd8);
    @(negedge clk);

    // Randomized loads with random holds and occasional retargets
    for (int k = 0; k < 25; k++) begin
      t = int'($urandom_range(0, 127));
      r = int'($urandom_range(0, 3));
      hold = 1'b0;
      issue_load(t, r);
      i = 0;
      seen = 0;
      while (i < 3000 && seen == 0) begin
        if (done) begin
          seen = 1;
        end else begin
          hold = ($urandom_range(0, 7) == 0);
          if (!hold && $urandom_range(0, 49) == 0) begin
            issue_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
          end else begin
            @(negedge clk);
          end
          i++;
        end
      end
      if (seen == 0) check("rand_timeout", 32'(done), 32'd1);
      hold = 1'b0;
      @(negedge clk);
    end

    // Asynchronous reset mid-ramp at 37
    settle_at(0);
    issue_load(80, 0);
    wait_dc(37, 100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dc", 32'(dc_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    issue_load(5, 0);
    wait_done(50);
    check("post_rst_dc", 32'(dc_out), 32'd5);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
